// File: rtl/print_scheduler.sv
// Print output scheduler: buffers print requests in a small FIFO and presents
// each word on print_dados for at least HOLD_CYCLES cycles.
module print_scheduler #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int CNT_W       = 26
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              print_out,
  input  logic [DATA_W-1:0] Rs,
  output logic              stall,
  output logic [DATA_W-1:0] print_dados,
  output logic              new_value,
  output logic              busy,
  output logic [7:0]        print_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]      FULL_CNT  = (AW+1)'(DEPTH);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t            state_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wptr_q, rptr_q;
  logic [AW:0]       count_q, count_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] dados_q;
  logic              new_value_q;
  logic [7:0]        print_count_q;
  logic              full, empty, push, pop;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  // Full is the registered occupancy, so a same-cycle pop never frees room.
  assign push  = print_out && !full;
  assign pop   = !empty && ((state_q == IDLE) || (cnt_q == '0));

  assign stall       = print_out && full;
  assign busy        = (state_q == HOLD) || !empty;
  assign print_dados = dados_q;
  assign new_value   = new_value_q;
  assign print_count = print_count_q;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= Rs;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      dados_q       <= '0;
      new_value_q   <= 1'b0;
      print_count_q <= 8'd0;
    end else begin
      new_value_q <= 1'b0;
      if (pop) begin
        dados_q       <= mem_q[rptr_q];
        new_value_q   <= 1'b1;
        print_count_q <= print_count_q + 8'd1;
        cnt_q         <= HOLD_LOAD;
        state_q       <= HOLD;
      end else if (state_q == HOLD) begin
        if (cnt_q != '0) cnt_q   <= cnt_q - 1'b1;
        else             state_q <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_print_scheduler.sv
// Self-checking bench for print_scheduler: directed and random traffic compared
// against a queue/timestamp model, at HOLD_CYCLES=4 and HOLD_CYCLES=1.
module tb_print_scheduler;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        print_out;
  logic [31:0] Rs;
  logic        sel;

  logic        d0_stall, d0_nv, d0_busy;
  logic [31:0] d0_dados;
  logic [7:0]  d0_cnt;
  logic        d1_stall, d1_nv, d1_busy;
  logic [31:0] d1_dados;
  logic [7:0]  d1_cnt;

  logic        o_stall, o_nv, o_busy;
  logic [31:0] o_dados;
  logic [7:0]  o_cnt;

  int checks = 0;
  int errors = 0;

  // reference model: pending words plus the edge index of the last load
  logic [31:0] mq[$];
  bit          m_active;
  int          m_edge, m_last, m_hold;
  logic [31:0] m_dados;
  logic        m_nv;
  logic [7:0]  m_cnt;

  print_scheduler #(.DATA_W(32), .DEPTH(DEPTH), .HOLD_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .print_out(print_out), .Rs(Rs),
    .stall(d0_stall), .print_dados(d0_dados), .new_value(d0_nv),
    .busy(d0_busy), .print_count(d0_cnt)
  );

  print_scheduler #(.DATA_W(32), .DEPTH(DEPTH), .HOLD_CYCLES(1), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .print_out(print_out), .Rs(Rs),
    .stall(d1_stall), .print_dados(d1_dados), .new_value(d1_nv),
    .busy(d1_busy), .print_count(d1_cnt)
  );

  assign o_stall = sel ? d1_stall : d0_stall;
  assign o_nv    = sel ? d1_nv    : d0_nv;
  assign o_busy  = sel ? d1_busy  : d0_busy;
  assign o_dados = sel ? d1_dados : d0_dados;
  assign o_cnt   = sel ? d1_cnt   : d0_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_active = 1'b0;
    m_edge   = 0;
    m_last   = 0;
    m_dados  = '0;
    m_nv     = 1'b0;
    m_cnt    = 8'd0;
  endtask

  task automatic model_edge(input logic po, input logic [31:0] d);
    int pre_size;
    m_edge++;
    pre_size = mq.size();
    m_nv = 1'b0;
    if (pre_size > 0 && (!m_active || (m_edge - m_last) >= m_hold)) begin
      m_dados  = mq.pop_front();
      m_nv     = 1'b1;
      m_cnt    = m_cnt + 8'd1;
      m_last   = m_edge;
      m_active = 1'b1;
    end else if (m_active && (m_edge - m_last) >= m_hold) begin
      m_active = 1'b0;
    end
    if (po && pre_size < DEPTH) mq.push_back(d);
  endtask

  task automatic check_all();
    chk("dados", o_dados, m_dados);
    chk("new_value", o_nv, m_nv);
    chk("print_count", o_cnt, m_cnt);
    chk("busy", o_busy, m_active || (mq.size() > 0));
  endtask

  task automatic step(input logic po, input logic [31:0] d);
    print_out = po;
    Rs        = d;
    #1;
    chk("stall", o_stall, po && (mq.size() == DEPTH));
    @(posedge clk);
    model_edge(po, d);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 32'h0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    print_out = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rst_dados", o_dados, 32'h0);
    chk("rst_new_value", o_nv, 1'b0);
    chk("rst_print_count", o_cnt, 8'd0);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_stall", o_stall, 1'b0);
    print_out = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int accepted;
    logic po;
    rst_n     = 1'b1;
    print_out = 1'b0;
    Rs        = '0;
    sel       = 1'b0;
    m_hold    = 4;
    model_reset();

    do_reset();

    // single push
    step(1'b1, 32'h1234_5678);
    step(1'b0, 32'h0);
    chk("single_dados", o_dados, 32'h1234_5678);
    chk("single_pulse", o_nv, 1'b1);
    idle(4);
    chk("single_idle", o_busy, 1'b0);
    idle(6);
    chk("single_retain", o_dados, 32'h1234_5678);

    // burst of three
    step(1'b1, 32'hA);
    step(1'b1, 32'hB);
    step(1'b1, 32'hC);
    idle(16);
    chk("burst_count", o_cnt, 8'd4);
    chk("burst_last", o_dados, 32'hC);

    // fill to full, F stalls once then is retried
    for (int i = 0; i < 5; i++) step(1'b1, 32'hA0 + i);
    step(1'b1, 32'hA5);
    step(1'b1, 32'hA5);
    idle(30);
    chk("full_last", o_dados, 32'hA5);
    chk("full_count", o_cnt, 8'd10);

    // random traffic
    for (int i = 0; i < 200; i++) step($urandom_range(2) != 0, $urandom);
    idle(30);

    // reset while holding with words queued
    for (int i = 0; i < 4; i++) step(1'b1, 32'hD0 + i);
    step(1'b0, 32'h0);
    chk("pre_rst_busy", o_busy, 1'b1);
    do_reset();
    idle(12);
    chk("post_rst_dados", o_dados, 32'h0);

    // HOLD_CYCLES=1: 256 loads wrap print_count
    sel    = 1'b1;
    m_hold = 1;
    do_reset();
    accepted = 0;
    while (accepted < 256) begin
      po = ($urandom_range(3) != 0);
      if (po && mq.size() < DEPTH) begin
        step(1'b1, 32'hC0DE_0000 + accepted);
        accepted++;
      end else begin
        step(po, 32'hDEAD_0000);
      end
    end
    idle(8);
    chk("wrap_count", o_cnt, 8'd0);
    chk("wrap_last", o_dados, 32'hC0DE_00FF);

    // back-to-back burst with stalls at HOLD_CYCLES=1
    for (int i = 0; i < 40; i++) step($urandom_range(4) != 0, $urandom);
    idle(8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
